// File: rtl/anim_datapath_pkg.sv
// ---------------------------------------------------------------------------
// anim_pkg: constants shared by the LED-animation sequencer and its datapath.
//   - ALU opcodes   ALU_ADD .. ALU_AND (3 bits)
//   - Write-data select codes WD_IMM, WD_INIT, WD_ALU, WD_ZERO (2 bits)
//   - Register index names used by the animation program
// ---------------------------------------------------------------------------
package anim_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b010;
    localparam logic [2:0] ALU_SLT = 3'b011;
    localparam logic [2:0] ALU_SLL = 3'b100;
    localparam logic [2:0] ALU_SRL = 3'b101;
    localparam logic [2:0] ALU_XOR = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b111;

    localparam logic [1:0] WD_IMM  = 2'b00;
    localparam logic [1:0] WD_INIT = 2'b01;
    localparam logic [1:0] WD_ALU  = 2'b10;
    localparam logic [1:0] WD_ZERO = 2'b11;

    localparam logic [2:0] R_LED   = 3'd0;
    localparam logic [2:0] R_BOUND = 3'd1;
    localparam logic [2:0] R_DELAY = 3'd2;
    localparam logic [2:0] R_MASK  = 3'd3;
    localparam logic [2:0] R_SHIFT = 3'd4;

endpackage

// File: rtl/anim_datapath_if.sv
// ---------------------------------------------------------------------------
// anim_datapath_if: control/status bundle between the animation sequencer
// (master) and the execution datapath (slave).
//   master drives : ra1, ra2, rf_we, wa, imm, wd_sel, alu_op, ld_we,
//                   c_enable, c_limit_we, c_reset
//   slave drives  : isZero, limit_reached
// ---------------------------------------------------------------------------
interface anim_datapath_if;
    logic [2:0]  ra1;
    logic [2:0]  ra2;
    logic        rf_we;
    logic [2:0]  wa;
    logic [31:0] imm;
    logic [1:0]  wd_sel;
    logic [2:0]  alu_op;
    logic        ld_we;
    logic        c_enable;
    logic        c_limit_we;
    logic        c_reset;
    logic        isZero;
    logic        limit_reached;

    modport master (
        output ra1, ra2, rf_we, wa, imm, wd_sel, alu_op, ld_we,
               c_enable, c_limit_we, c_reset,
        input  isZero, limit_reached
    );

    modport slave (
        input  ra1, ra2, rf_we, wa, imm, wd_sel, alu_op, ld_we,
               c_enable, c_limit_we, c_reset,
        output isZero, limit_reached
    );
endinterface

// File: rtl/anim_datapath_alu.sv
// ---------------------------------------------------------------------------
// anim_alu: purely combinational 32-bit ALU, carry/overflow discarded.
//   a, b   : operands
//   op     : ALU_* opcode from anim_pkg
//   result : operation result
//   zero   : result == 0
// ---------------------------------------------------------------------------
module anim_alu
    import anim_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  op,
    output logic [31:0] result,
    output logic        zero
);

    always_comb begin
        result = '0;
        unique case (op)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_OR:  result = a | b;
            ALU_SLT: result = {31'b0, (a < b)};   // unsigned compare
            ALU_SLL: result = a << b[4:0];
            ALU_SRL: result = a >> b[4:0];
            ALU_XOR: result = a ^ b;
            ALU_AND: result = a & b;
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/anim_datapath.sv
// ---------------------------------------------------------------------------
// anim_datapath: execution datapath of the LED-animation sequencer.
// 8x32 register file (2 combinational read ports, 1 write port), ALU,
// LED output register and 32-bit frame-delay counter with limit.
//
// Parameters : LED_W (LED register width, <= 32), INIT_PATTERN (wd_sel=01 data)
// Ports      : clk, reset (async, active-high)
//              ctrl   - anim_datapath_if.slave (controls in, isZero/limit_reached out)
//              leds   - LED register
// Optional   : ANIM_DP_DBG_EN adds dbg_ra (in), dbg_rd = R[dbg_ra] and
//              dbg_count = count (out).
// ---------------------------------------------------------------------------
module anim_datapath
    import anim_pkg::*;
#(
    parameter int          LED_W        = 8,
    parameter logic [31:0] INIT_PATTERN = 32'h1
) (
    input  logic             clk,
    input  logic             reset,
    anim_datapath_if.slave   ctrl,
`ifdef ANIM_DP_DBG_EN
    input  logic [2:0]       dbg_ra,
    output logic [31:0]      dbg_rd,
    output logic [31:0]      dbg_count,
`endif
    output logic [LED_W-1:0] leds
);

    logic [31:0]      rf_reg [8];
    logic [31:0]      rd1;
    logic [31:0]      rd2;
    logic [31:0]      alu_result;
    logic             alu_zero;
    logic [31:0]      wd_next;
    logic [LED_W-1:0] leds_reg;
    logic [31:0]      count_reg;
    logic [31:0]      limit_reg;

    // Reads are combinational from the current array contents, so a read of
    // the register being written returns the old value.
    assign rd1 = rf_reg[ctrl.ra1];
    assign rd2 = rf_reg[ctrl.ra2];

    anim_alu u_alu (
        .a      (rd1),
        .b      (rd2),
        .op     (ctrl.alu_op),
        .result (alu_result),
        .zero   (alu_zero)
    );

    always_comb begin
        wd_next = '0;
        unique case (ctrl.wd_sel)
            WD_IMM:  wd_next = ctrl.imm;
            WD_INIT: wd_next = INIT_PATTERN;
            WD_ALU:  wd_next = alu_result;
            WD_ZERO: wd_next = '0;
            default: wd_next = '0;
        endcase
    end

    // Register file: cleared by reset so the animation always starts from a
    // known state; none of the entries is hardwired.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                rf_reg[i] <= '0;
            end
        end else if (ctrl.rf_we) begin
            rf_reg[ctrl.wa] <= wd_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            leds_reg <= '0;
        end else if (ctrl.ld_we) begin
            leds_reg <= rd1[LED_W-1:0];
        end
    end

    // Delay counter. The increment guard uses the limit as it was before this
    // edge, so a simultaneous limit load does not affect the current step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
            limit_reg <= '0;
        end else begin
            if (ctrl.c_reset) begin
                count_reg <= '0;
            end else if (ctrl.c_enable && (count_reg != limit_reg)) begin
                count_reg <= count_reg + 32'd1;
            end
            if (ctrl.c_limit_we) begin
                limit_reg <= rd1;
            end
        end
    end

    assign ctrl.isZero        = alu_zero;
    assign ctrl.limit_reached = (count_reg == limit_reg);
    assign leds               = leds_reg;

`ifdef ANIM_DP_DBG_EN
    assign dbg_rd    = rf_reg[dbg_ra];
    assign dbg_count = count_reg;
`endif

endmodule

// File: tb/tb_anim_datapath.sv
// ---------------------------------------------------------------------------
// tb_anim_datapath: self-checking bench for anim_datapath. Directed steps
// plus a randomized phase, compared against a behavioural model of the
// register file, ALU, LED register and delay counter.
// ---------------------------------------------------------------------------
module tb_anim_datapath;
    import anim_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] leds;

    always #5 clk = ~clk;

    anim_datapath_if bus ();

`ifdef ANIM_DP_DBG_EN
    logic [2:0]  dbg_ra;
    logic [31:0] dbg_rd;
    logic [31:0] dbg_count;
`endif

    anim_datapath #(
        .LED_W        (8),
        .INIT_PATTERN (32'h1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ctrl      (bus.slave),
`ifdef ANIM_DP_DBG_EN
        .dbg_ra    (dbg_ra),
        .dbg_rd    (dbg_rd),
        .dbg_count (dbg_count),
`endif
        .leds      (leds)
    );

    // Behavioural model state
    logic [31:0] m_r [8];
    logic [7:0]  m_leds;
    logic [31:0] m_cnt;
    logic [31:0] m_lim;

    int checks   = 0;
    int failures = 0;

    function automatic logic [31:0] ref_alu(input logic [2:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        int unsigned sh;
        sh = b % 32;
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a | b;
            3'd3:    return (a < b) ? 32'd1 : 32'd0;
            3'd4:    return a * (32'd1 << sh);
            3'd5:    return a / (32'd1 << sh);
            3'd6:    return a ^ b;
            default: return a & b;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_r[i] = '0;
        m_leds = '0;
        m_cnt  = '0;
        m_lim  = '0;
    endtask

    task automatic idle();
        bus.ra1 = 0; bus.ra2 = 0; bus.rf_we = 0; bus.wa = 0; bus.imm = 0;
        bus.wd_sel = WD_IMM; bus.alu_op = ALU_ADD; bus.ld_we = 0;
        bus.c_enable = 0; bus.c_limit_we = 0; bus.c_reset = 0;
    endtask

    // One clock with the currently driven controls: check the zero-latency
    // feedback, advance the model at the edge, check the LED register after.
    task automatic cycle(input string tag);
        logic [31:0] a, b, res, wd;
        #1;
        a   = m_r[bus.ra1];
        b   = m_r[bus.ra2];
        res = ref_alu(bus.alu_op, a, b);
        check({tag, ":zero"},  32'(bus.isZero),        32'(res == 0));
        check({tag, ":limit"}, 32'(bus.limit_reached), 32'(m_cnt == m_lim));
`ifdef ANIM_DP_DBG_EN
        check({tag, ":dbg_count"}, dbg_count, m_cnt);
`endif
        @(posedge clk);
        case (bus.wd_sel)
            WD_IMM:  wd = bus.imm;
            WD_INIT: wd = 32'h1;
            WD_ALU:  wd = res;
            default: wd = 32'h0;
        endcase
        if (bus.rf_we) m_r[bus.wa] = wd;
        if (bus.ld_we) m_leds = a[7:0];
        if (bus.c_reset)                         m_cnt = 0;
        else if (bus.c_enable && m_cnt != m_lim) m_cnt = m_cnt + 1;
        if (bus.c_limit_we) m_lim = a;
        @(negedge clk);
        check({tag, ":leds"}, 32'(leds), 32'(m_leds));
    endtask

    task automatic wr_imm(input logic [2:0] wa, input logic [31:0] v);
        idle();
        bus.rf_we = 1; bus.wa = wa; bus.imm = v; bus.wd_sel = WD_IMM;
        cycle("wr_imm");
    endtask

    // Full 32-bit register compare: load the expected value into a scratch
    // register and XOR it against the target; isZero must be set.
    task automatic check_reg(input logic [2:0] r, input logic [31:0] exp,
                             input string tag);
        logic [2:0] s;
        s = (r == 3'd7) ? 3'd6 : 3'd7;
        wr_imm(s, exp);
        idle();
        bus.ra1 = r; bus.ra2 = s; bus.alu_op = ALU_XOR;
        #1;
        check(tag, 32'(bus.isZero), 32'd1);
    endtask

    task automatic alu_wr(input logic [2:0] op, input logic [2:0] a,
                          input logic [2:0] b, input logic [2:0] wa,
                          input logic [31:0] exp, input string tag);
        idle();
        bus.alu_op = op; bus.ra1 = a; bus.ra2 = b;
        bus.rf_we = 1; bus.wa = wa; bus.wd_sel = WD_ALU;
        #1;
        check({tag, ":isZero"}, 32'(bus.isZero), 32'(exp == 0));
        cycle(tag);
        check_reg(wa, exp, {tag, ":result"});
    endtask

    initial begin
        int n;
        model_reset();
        idle();
`ifdef ANIM_DP_DBG_EN
        dbg_ra = 0;
`endif
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset state
        #1;
        check("rst_leds",  32'(leds), 32'd0);
        check("rst_limit", 32'(bus.limit_reached), 32'd1);
        check("rst_zero",  32'(bus.isZero), 32'd1);
        @(negedge clk);

        // Basic writes and ADD
        wr_imm(R_BOUND, 32'h100);
        idle(); bus.rf_we = 1; bus.wa = R_LED; bus.wd_sel = WD_INIT;
        cycle("wr_init");
        check_reg(R_BOUND, 32'h100, "r1_val");
        check_reg(R_LED,   32'h1,   "r0_val");
        alu_wr(ALU_ADD, R_LED, R_BOUND, 3'd5, 32'h101, "add");

        // ALU edge cases
        wr_imm(3'd2, 32'h80);
        wr_imm(R_MASK, 32'hFF);
        wr_imm(R_SHIFT, 32'h1);
        wr_imm(3'd6, 32'h0);
        alu_wr(ALU_SLT, 3'd2, R_BOUND, 3'd5, 32'h1, "slt_lt");
        alu_wr(ALU_SLT, R_BOUND, R_BOUND, 3'd5, 32'h0, "slt_eq");
        alu_wr(ALU_SLL, 3'd2, R_SHIFT, 3'd5, 32'h100, "sll");
        alu_wr(ALU_AND, R_BOUND, R_MASK, 3'd5, 32'h0, "and");
        alu_wr(ALU_SUB, 3'd6, R_SHIFT, 3'd5, 32'hFFFF_FFFF, "sub");
        alu_wr(ALU_SRL, R_BOUND, R_SHIFT, 3'd5, 32'h80, "srl");
        alu_wr(ALU_OR,  3'd2, R_BOUND, 3'd5, 32'h180, "or");

        // Rotation loop: 0x80 wraps back to 0x01
        wr_imm(R_LED, 32'h80);
        alu_wr(ALU_SLL, R_LED, R_SHIFT, R_LED, 32'h100, "rot_sll");
        alu_wr(ALU_SLT, R_LED, R_BOUND, 3'd5, 32'h0, "rot_slt");
        alu_wr(ALU_AND, R_LED, R_MASK, R_LED, 32'h0, "rot_and");
        alu_wr(ALU_ADD, R_LED, R_SHIFT, R_LED, 32'h1, "rot_add");
        idle(); bus.ld_we = 1; bus.ra1 = R_LED;
        cycle("rot_ld");
        check("rot_leds", 32'(leds), 32'h01);

        // Counter: limit 5, reset, then continuous enable
        wr_imm(R_DELAY, 32'd5);
        idle(); bus.ra1 = R_DELAY; bus.c_limit_we = 1; bus.c_reset = 1;
        cycle("cnt_load");
        idle(); bus.c_enable = 1;
        n = 0;
        #1;
        while (!bus.limit_reached && n < 20) begin
            cycle("cnt_en");
            n++;
            #1;
        end
        check("cnt_len", 32'(n), 32'd5);
        repeat (3) cycle("cnt_hold");
        #1;
        check("cnt_sat", 32'(bus.limit_reached), 32'd1);
        idle(); bus.c_reset = 1; bus.c_enable = 1;
        cycle("cnt_rst_en");
        #1;
        check("cnt_cleared", 32'(bus.limit_reached), 32'd0);
`ifdef ANIM_DP_DBG_EN
        check("cnt_zero_dbg", dbg_count, 32'd0);
        wr_imm(3'd2, 32'h17D7840);
        dbg_ra = 3'd2;
        #1;
        check("dbg_rd", dbg_rd, 32'h17D7840);
`endif

        // Randomized phase
        for (int i = 0; i < 300; i++) begin
            idle();
            bus.ra1        = 3'($urandom_range(0, 7));
            bus.ra2        = 3'($urandom_range(0, 7));
            bus.wa         = 3'($urandom_range(0, 7));
            bus.rf_we      = 1'($urandom_range(0, 1));
            bus.imm        = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 12))
                                                          : 32'($urandom);
            bus.wd_sel     = 2'($urandom_range(0, 3));
            bus.alu_op     = 3'($urandom_range(0, 7));
            bus.ld_we      = 1'($urandom_range(0, 1));
            bus.c_enable   = ($urandom_range(0, 3) != 0);
            bus.c_limit_we = ($urandom_range(0, 7) == 0);
            bus.c_reset    = ($urandom_range(0, 15) == 0);
            cycle("rand");
        end
        for (int r = 0; r < 8; r++) begin
            logic [31:0] v;
            v = m_r[r];
            check_reg(3'(r), v, "rand_reg");
        end

        // Asynchronous reset in the middle of a write
        idle(); bus.rf_we = 1; bus.wa = 3'd3; bus.imm = 32'hDEAD_BEEF;
        bus.ld_we = 1; bus.ra1 = 3'd3;
        #2;
        reset = 1'b1;
        model_reset();
        idle();
        #1;
        check("mid_rst_leds",  32'(leds), 32'd0);
        check("mid_rst_limit", 32'(bus.limit_reached), 32'd1);
        check("mid_rst_zero",  32'(bus.isZero), 32'd1);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int r = 0; r < 8; r++) begin
            bus.ra1 = 3'(r); bus.ra2 = 3'(r); bus.alu_op = ALU_OR;
            #1;
            check("mid_rst_reg", 32'(bus.isZero), 32'd1);
        end
        idle();
        cycle("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/anim_datapath.md
# anim_datapath

Execution datapath driven by the LED-animation sequencer. It holds an 8×32 register file, a 3-bit-opcode ALU with a zero flag, the LED output register and the frame-delay counter. It consumes every control output of the sequencer (register addresses, write enable, immediate, write-data select, ALU op, LED load, counter controls). It returns `isZero` and `limit_reached` to the sequencer.

## Interface
- `LED_W`, default 8: width of LED output register and `leds` port.
- `INIT_PATTERN`, default 32'h1: constant written when `wd_sel`=01.
- `clk`  in  1  clock.
- `reset`  in  1  reset, asynchronous, active-high; clock clk.
- `ra1`  in  3  register-file read address A (ALU operand A, LED/limit source).
- `ra2`  in  3  read address B (ALU operand B).
- `rf_we`  in  1  register-file write enable.
- `wa`  in  3  write address.
- `imm`  in  32  immediate write data.
- `wd_sel`  in  2  write-data select: 00 imm, 01 INIT_PATTERN, 10 ALU result, 11 zero.
- `alu_op`  in  3  ALU operation.
- `ld_we`  in  1  load LED register from rd1[LED_W-1:0].
- `c_enable`  in  1  delay counter increment.
- `c_limit_we`  in  1  load counter limit from rd1.
- `c_reset`  in  1  clear count.
- `isZero`  out  1  ALU result == 0, combinational.
- `limit_reached`  out  1  count == limit, combinational from registers.
- `leds`  out  LED_W  LED register.

## Operation
- Register file: 8 × 32-bit, two combinational read ports (rd1=R[ra1], rd2=R[ra2]), one write port on posedge clk when `rf_we`. No register is hardwired. Read-during-write returns the old value.
- ALU (a=rd1, b=rd2, 32-bit, carry/overflow dropped):
  - 000 ADD a+b
  - 001 SUB a−b (mod 2^32)
  - 010 OR
  - 011 SLT unsigned, result 1 when a<b, else 0
  - 100 SLL a<<b[4:0]
  - 101 SRL a>>b[4:0]
  - 110 XOR
  - 111 AND
- `isZero` is the combinational result==0.
- LED register: on `ld_we`, leds ← rd1[LED_W-1:0]. Otherwise it holds.
- Delay counter: 32-bit count and 32-bit limit.
  - Priority per cycle: `c_reset` clears count; else `c_enable` increments count only while count≠limit (saturates at limit).
  - `c_limit_we` loads limit independently. When it coincides with `c_enable`, the increment compares against the old limit.
  - `limit_reached` = (count==limit), regardless of `c_enable`.
  - Limit 0 gives `limit_reached`=1 immediately after reset or `c_reset`.

## Timing
- Reset (async): all 8 registers, leds, count and limit = 0. Hence `limit_reached`=1 and, with all operands 0, `isZero`=1.
- Control inputs arrive registered and aligned with the sequencer state. Each control takes effect at the next posedge (one-cycle write latency).
- `isZero` and `limit_reached` are valid in the same cycle as the controls and registers that produce them (zero-latency feedback).
- Starting from `c_reset`, `limit_reached` rises on the cycle after `limit` consecutive enabled cycles.
- Reset mid-operation clears everything immediately. No pending write survives.

## Configuration
- `ANIM_DP_DBG_EN` defined:
  - adds input `dbg_ra` [2:0] and output `dbg_rd` [31:0] = R[dbg_ra], a combinational third read port;
  - adds output `dbg_count` [31:0] = count.
- Not defined: these ports and their logic are absent; behaviour is otherwise identical.

## Structure
- Shared package `anim_pkg` holds:
  - ALU opcode constants `ALU_ADD … ALU_AND`;
  - `wd_sel` codes `WD_IMM`, `WD_INIT`, `WD_ALU`, `WD_ZERO`;
  - register index names `R_LED`=0, `R_BOUND`=1, `R_DELAY`=2, `R_MASK`=3, `R_SHIFT`=4.
- One sub-module: `anim_alu` (purely combinational: a, b, op → result, zero). The register file and counter stay inline.

## Test plan
- Reset: assert reset mid-run → leds=0, `limit_reached`=1, `isZero`=1, R[0..7]=0.
- Writes: wa=1, imm=32'h100, wd_sel=00; then wa=0, wd_sel=01. → R1=0x100, R0=1. ADD ra1=0, ra2=1 → result 0x101, `isZero`=0.
- ALU edges:
  - SLT 0x80<0x100 → 1;
  - SLT 0x100<0x100 → 0 with `isZero`=1;
  - SLL 0x80 by 1 → 0x100;
  - AND 0x100 & 0xFF → 0, `isZero`=1;
  - SUB 0−1 → 0xFFFFFFFF.
- Rotation loop: run the sequencer pattern (SLL, SLT bound, AND mask, ADD 1) from R0=0x80 → R0=0x01. `ld_we` → leds=8'h01.
- Counter:
  - load limit 5 via `c_limit_we`, `c_reset`, then hold `c_enable` → `limit_reached` rises after exactly 5 enabled cycles and count holds at 5;
  - `c_reset` together with `c_enable` → count=0.
- With `ANIM_DP_DBG_EN`: `dbg_ra`=2 after writing 32'h17D7840 to R2 → `dbg_rd`=32'h17D7840.
